branch_resolve: RTL and testbench
=================================

# branch_resolve

Execute-side consumer of the fetch-stage branch predictions. Every branch or jump that fetch predicts is pushed here with its predicted direction and next PC. The entry waits in an in-order queue until execute reports the real outcome. When prediction and actual next PC disagree, the block flushes all younger predictions and issues a one-cycle registered redirect back to fetch.

## Interface
Parameters:
- DEPTH, 4: queue entries; power of two, 2..16.

Ports:
- clock, input, 1: sole clock; all state updates on the rising edge.
- reset, input, 1: asynchronous, active-low; clears all state immediately.
- pred_valid_i, input, 1: fetch offers one prediction (only for is_branch instructions).
- pred_ready_o, output, 1: queue accepts a prediction this cycle.
- pred_pc_i, input, 32: PC of the predicted control-flow instruction.
- pred_taken_i, input, 1: predicted direction.
- pred_dnpc_i, input, 32: predicted target; only meaningful when pred_taken_i=1.
- resolve_valid_i, input, 1: execute presents the actual outcome of the oldest branch.
- resolve_ready_o, output, 1: resolution consumed this cycle.
- resolve_pc_i, input, 32: PC of the resolved instruction.
- resolve_taken_i, input, 1: actual direction.
- resolve_target_i, input, 32: actual target.
- redirect_o, output, 1: one-cycle pulse; fetch must restart at redirect_pc_o.
- redirect_pc_o, output, 32: correct next PC, held until the next redirect.
- error_o, output, 1: sticky; head PC did not match resolve_pc_i.

## Operation
- The FSM has two states, RUN and REDIRECT; reset enters RUN.
- Push: fires on pred_valid_i && pred_ready_o.
  - pred_ready_o = (state==RUN) && !full.
  - It has no combinational dependency on the resolve side, so a full queue with a simultaneous pop still refuses the push.
- Resolve: fires on resolve_valid_i && resolve_ready_o, and pops the head entry.
  - resolve_ready_o = (state==RUN) && !empty.
  - There is no bypass: a push and a resolve in the same cycle on an empty queue does not resolve.
- Comparison uses head entry H and the resolve inputs.
  - Predicted next PC P = H.taken ? H.dnpc : H.pc+4.
  - Actual next PC A = resolve_taken_i ? resolve_target_i : resolve_pc_i+4.
  - All arithmetic is 32-bit and wraps modulo 2^32.
- Mismatch condition: (P != A) || (H.pc != resolve_pc_i).
  - A PC mismatch also sets error_o, which clears only on reset.
- On a match: pop only, state stays RUN.
- On a mismatch:
  - The queue is cleared at that edge, including any push accepted in the same cycle, since that entry is younger.
  - redirect_pc_o <= A.
  - State moves to REDIRECT.
- REDIRECT lasts one cycle:
  - redirect_o=1 and both ready outputs are 0.
  - The next state is always RUN.
- Reset mid-operation (any state) has the same effect as power-on reset: queue empty, state RUN, no pending redirect.

## Timing
- Reset values:
  - redirect_o=0, redirect_pc_o=0, error_o=0.
  - pred_ready_o=1 and resolve_ready_o=0 (state RUN, queue empty).
  - Counters are 0 when the macro is enabled.
- Push to resolvable: an entry pushed at edge N can be resolved in cycle N+1 at the earliest.
- Mispredicting resolve in cycle N:
  - redirect_o is high in cycle N+1 only.
  - pred_ready_o returns to 1 in cycle N+2.
- A correct resolve costs no bubble; one push and one pop per cycle are sustained.
- Back-to-back mispredicts are separated by at least 2 cycles.

## Configuration
- BRANCH_RESOLVE_STAT_EN defined:
  - Adds outputs branch_cnt_o[31:0], which counts every resolve handshake.
  - Adds mispredict_cnt_o[31:0], which counts every mismatch.
  - Both counters wrap at 2^32 and are reset to 0.
- BRANCH_RESOLVE_STAT_EN undefined: both ports and the counters are absent, and the functional behaviour is identical.

## Structure
- defines.v holds:
  - BRQ_STATE_RUN and BRQ_STATE_REDIRECT encodings.
  - BRQ_PC_INC (32'd4).
  - The entry width constant (65 bits: pc, taken, dnpc).
- Sub-module branch_queue is a synchronous FIFO.
  - Ports: push, pop, clear, full, empty, head data.
  - Pointers are log2(DEPTH)+1 bits, with the extra bit used to tell full from empty.
- branch_resolve holds the FSM, the comparison logic, the redirect registers and the optional counters.

## Test plan
- Correct not-taken: push {pc=0x80000010, taken=0}, resolve {pc=0x80000010, taken=0} -> no redirect, queue empty after.
- Direction mispredict: push {pc=0x80000020, taken=0}, resolve {taken=1, target=0x80000100} -> redirect_o pulses the next cycle with redirect_pc_o=0x80000100; pred_ready_o=0 that cycle and 1 the cycle after.
- Target mispredict with younger entries: push 3 entries where the oldest is {pc=0x80000000, taken=1, dnpc=0x80000040}; resolve the oldest with target 0x80000080 -> redirect to 0x80000080, all 3 entries flushed, resolve_ready_o=0 after REDIRECT.
- Full queue: DEPTH=4, push 4 entries -> pred_ready_o=0; a 5th pred_valid_i with a simultaneous matching resolve -> pop accepted, 5th push refused, accepted the following cycle.
- PC mismatch: head pc=0x80000004, resolve_pc_i=0x80000008 with taken=0 -> error_o=1 stays set, redirect_pc_o=0x8000000C.
- Async reset during REDIRECT: assert reset mid-cycle -> redirect_o drops immediately, queue empty, counters 0 (with the macro enabled), error_o=0.

Source files
------------

// File: rtl/branch_resolve_pkg.sv
// Shared types and constants for the branch resolution queue.
// Holds the FSM encoding, the PC increment and the queue entry layout.
package branch_resolve_pkg;

  localparam logic [31:0] BRQ_PC_INC  = 32'd4;
  localparam int          BRQ_ENTRY_W = 65;

  typedef enum logic {
    BRQ_STATE_RUN      = 1'b0,
    BRQ_STATE_REDIRECT = 1'b1
  } brq_state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic        taken;
    logic [31:0] dnpc;
  } brq_entry_t;

  function automatic logic [31:0] brq_next_pc(input logic taken, input logic [31:0] target,
                                              input logic [31:0] pc);
    return taken ? target : pc + BRQ_PC_INC;
  endfunction

endpackage

// File: rtl/branch_queue.sv
// In-order prediction FIFO; head visible combinationally, push visible to the head one cycle later.
// clear_i wins over push_i and pop_i so a flush also drops a same-cycle push.
module branch_queue #(
  parameter int DEPTH = 4,
  parameter int W     = 65
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic         clear_i,
  input  logic [W-1:0] push_dat_i,
  output logic         full_o,
  output logic         empty_o,
  output logic [W-1:0] head_dat_o
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]  wr_ptr_q, wr_ptr_d;
  logic [AW:0]  rd_ptr_q, rd_ptr_d;
  logic [W-1:0] mem_q [DEPTH];

  assign empty_o    = (wr_ptr_q == rd_ptr_q);
  assign full_o     = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign head_dat_o = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (clear_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (push_i && !full_o) wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, 1'b1};
      if (pop_i && !empty_o) rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clock) begin
    if (push_i && !full_o && !clear_i) mem_q[wr_ptr_q[AW-1:0]] <= push_dat_i;
  end

endmodule

// File: rtl/branch_resolve.sv
// Compares fetch predictions against execute outcomes; a mismatch flushes and raises a 1-cycle redirect.
// Optional BRANCH_RESOLVE_STAT_EN adds resolve and mispredict counters.
module branch_resolve
  import branch_resolve_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        pred_valid_i,
  output logic        pred_ready_o,
  input  logic [31:0] pred_pc_i,
  input  logic        pred_taken_i,
  input  logic [31:0] pred_dnpc_i,
  input  logic        resolve_valid_i,
  output logic        resolve_ready_o,
  input  logic [31:0] resolve_pc_i,
  input  logic        resolve_taken_i,
  input  logic [31:0] resolve_target_i,
  output logic        redirect_o,
  output logic [31:0] redirect_pc_o,
  output logic        error_o
`ifdef BRANCH_RESOLVE_STAT_EN
  ,
  output logic [31:0] branch_cnt_o,
  output logic [31:0] mispredict_cnt_o
`endif
);

  brq_state_e             state_q, state_d;
  brq_entry_t             push_ent, head_ent;
  logic [BRQ_ENTRY_W-1:0] head_dat;
  logic                   full, empty, push, fire, pc_mis, mispredict;
  logic [31:0]            pred_npc, act_npc;
  logic [31:0]            redirect_pc_q, redirect_pc_d;
  logic                   error_q, error_d;

  assign push_ent = '{pc: pred_pc_i, taken: pred_taken_i, dnpc: pred_dnpc_i};
  assign head_ent = brq_entry_t'(head_dat);

  branch_queue #(.DEPTH(DEPTH), .W(BRQ_ENTRY_W)) u_queue (
    .clock      (clock),
    .reset      (reset),
    .push_i     (push),
    .pop_i      (fire),
    .clear_i    (mispredict),
    .push_dat_i (push_ent),
    .full_o     (full),
    .empty_o    (empty),
    .head_dat_o (head_dat)
  );

  // Ready depends only on local state so neither side sees a combinational path from the other.
  always_comb begin
    pred_ready_o    = (state_q == BRQ_STATE_RUN) && !full;
    resolve_ready_o = (state_q == BRQ_STATE_RUN) && !empty;
    redirect_o      = (state_q == BRQ_STATE_REDIRECT);
    push            = pred_valid_i && pred_ready_o;
    fire            = resolve_valid_i && resolve_ready_o;
    pred_npc        = brq_next_pc(head_ent.taken, head_ent.dnpc, head_ent.pc);
    act_npc         = brq_next_pc(resolve_taken_i, resolve_target_i, resolve_pc_i);
    pc_mis          = (head_ent.pc != resolve_pc_i);
    mispredict      = fire && ((pred_npc != act_npc) || pc_mis);
    state_d         = state_q;
    redirect_pc_d   = redirect_pc_q;
    error_d         = error_q;
    case (state_q)
      BRQ_STATE_RUN: begin
        if (mispredict) begin
          state_d       = BRQ_STATE_REDIRECT;
          redirect_pc_d = act_npc;
        end
      end
      BRQ_STATE_REDIRECT: state_d = BRQ_STATE_RUN;
    endcase
    if (fire && pc_mis) error_d = 1'b1;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q       <= BRQ_STATE_RUN;
      redirect_pc_q <= '0;
      error_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      redirect_pc_q <= redirect_pc_d;
      error_q       <= error_d;
    end
  end

  assign redirect_pc_o = redirect_pc_q;
  assign error_o       = error_q;

`ifdef BRANCH_RESOLVE_STAT_EN
  logic [31:0] branch_cnt_q, mispredict_cnt_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      branch_cnt_q     <= '0;
      mispredict_cnt_q <= '0;
    end else begin
      if (fire)       branch_cnt_q     <= branch_cnt_q + 32'd1;
      if (mispredict) mispredict_cnt_q <= mispredict_cnt_q + 32'd1;
    end
  end

  assign branch_cnt_o     = branch_cnt_q;
  assign mispredict_cnt_o = mispredict_cnt_q;
`else
  // Statistics disabled: no counter state exists.
`endif

endmodule

// File: tb/tb_branch_resolve.sv
// Bench for branch_resolve: a queue model predicts readies, redirects and errors each cycle.
// Expected redirect PCs are queued at the mispredicting resolve and popped when redirect_o rises.
module tb_branch_resolve;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        pred_valid_i = 1'b0, pred_taken_i = 1'b0;
  logic [31:0] pred_pc_i = '0, pred_dnpc_i = '0;
  logic        resolve_valid_i = 1'b0, resolve_taken_i = 1'b0;
  logic [31:0] resolve_pc_i = '0, resolve_target_i = '0;
  logic        pred_ready_o, resolve_ready_o, redirect_o, error_o;
  logic [31:0] redirect_pc_o;
`ifdef BRANCH_RESOLVE_STAT_EN
  logic [31:0] branch_cnt_o, mispredict_cnt_o;
`endif

  always #5 clock = ~clock;

  branch_resolve #(.DEPTH(4)) dut (
    .clock            (clock),
    .reset            (reset),
    .pred_valid_i     (pred_valid_i),
    .pred_ready_o     (pred_ready_o),
    .pred_pc_i        (pred_pc_i),
    .pred_taken_i     (pred_taken_i),
    .pred_dnpc_i      (pred_dnpc_i),
    .resolve_valid_i  (resolve_valid_i),
    .resolve_ready_o  (resolve_ready_o),
    .resolve_pc_i     (resolve_pc_i),
    .resolve_taken_i  (resolve_taken_i),
    .resolve_target_i (resolve_target_i),
    .redirect_o       (redirect_o),
    .redirect_pc_o    (redirect_pc_o),
    .error_o          (error_o)
`ifdef BRANCH_RESOLVE_STAT_EN
    ,
    .branch_cnt_o     (branch_cnt_o),
    .mispredict_cnt_o (mispredict_cnt_o)
`endif
  );

  typedef struct {
    logic [31:0] pc;
    logic        taken;
    logic [31:0] dnpc;
  } ent_t;

  int          n_checks = 0;
  int          n_fail   = 0;
  ent_t        mq[$];
  logic [31:0] exp_q[$];
  logic        m_redir, m_err;
  logic [31:0] m_rpc, m_bcnt, m_mcnt;

  task automatic model_reset();
    mq.delete();
    exp_q.delete();
    m_redir = 1'b0;
    m_err   = 1'b0;
    m_rpc   = '0;
    m_bcnt  = '0;
    m_mcnt  = '0;
  endtask

  // One clock cycle: drive after the edge, check at the falling edge, then advance the model.
  task automatic step(input logic pv, input logic [31:0] ppc, input logic pt, input logic [31:0] pd,
                      input logic rv, input logic [31:0] rpc, input logic rt, input logic [31:0] rtgt);
    logic        m_prdy, m_rrdy, push, fire, mis, pcm;
    logic [31:0] pn, an, e;
    ent_t        h, n;
    @(posedge clock);
    #1;
    pred_valid_i     = pv;
    pred_pc_i        = ppc;
    pred_taken_i     = pt;
    pred_dnpc_i      = pd;
    resolve_valid_i  = rv;
    resolve_pc_i     = rpc;
    resolve_taken_i  = rt;
    resolve_target_i = rtgt;
    @(negedge clock);
    m_prdy = !m_redir && (mq.size() < 4);
    m_rrdy = !m_redir && (mq.size() != 0);
    n_checks++;
    if (pred_ready_o !== m_prdy) begin
      n_fail++;
      $display("FAIL pred_ready_o: got %b expected %b at %0t", pred_ready_o, m_prdy, $time);
    end
    n_checks++;
    if (resolve_ready_o !== m_rrdy) begin
      n_fail++;
      $display("FAIL resolve_ready_o: got %b expected %b at %0t", resolve_ready_o, m_rrdy, $time);
    end
    n_checks++;
    if (redirect_o !== m_redir) begin
      n_fail++;
      $display("FAIL redirect_o: got %b expected %b at %0t", redirect_o, m_redir, $time);
    end
    n_checks++;
    if (error_o !== m_err) begin
      n_fail++;
      $display("FAIL error_o: got %b expected %b at %0t", error_o, m_err, $time);
    end
    n_checks++;
    if (redirect_pc_o !== m_rpc) begin
      n_fail++;
      $display("FAIL redirect_pc_o: got %h expected %h at %0t", redirect_pc_o, m_rpc, $time);
    end
    if (redirect_o === 1'b1) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL redirect_sb: unexpected redirect to %h at %0t", redirect_pc_o, $time);
      end else begin
        e = exp_q.pop_front();
        if (redirect_pc_o !== e) begin
          n_fail++;
          $display("FAIL redirect_sb: got %h expected %h at %0t", redirect_pc_o, e, $time);
        end
      end
    end
`ifdef BRANCH_RESOLVE_STAT_EN
    n_checks++;
    if (branch_cnt_o !== m_bcnt || mispredict_cnt_o !== m_mcnt) begin
      n_fail++;
      $display("FAIL counters: got %0d/%0d expected %0d/%0d", branch_cnt_o, mispredict_cnt_o, m_bcnt, m_mcnt);
    end
`endif
    push = pv && m_prdy;
    fire = rv && m_rrdy;
    mis  = 1'b0;
    if (fire) begin
      h   = mq[0];
      pn  = h.taken ? h.dnpc : h.pc + 32'd4;
      an  = rt ? rtgt : rpc + 32'd4;
      pcm = (h.pc != rpc);
      mis = (pn != an) || pcm;
      m_bcnt++;
      if (pcm) m_err = 1'b1;
      if (mis) begin
        m_mcnt++;
        m_rpc = an;
        exp_q.push_back(an);
        mq.delete();
      end else begin
        void'(mq.pop_front());
      end
    end
    if (push && !mis) begin
      n.pc = ppc; n.taken = pt; n.dnpc = pd;
      mq.push_back(n);
    end
    m_redir = mis;
  endtask

  task automatic idle();
    step(0, '0, 0, '0, 0, '0, 0, '0);
  endtask

  task automatic push_only(input logic [31:0] pc, input logic t, input logic [31:0] d);
    step(1, pc, t, d, 0, '0, 0, '0);
  endtask

  task automatic drain();
    for (int i = 0; i < 8 && mq.size() > 0; i++)
      step(0, '0, 0, '0, 1, mq[0].pc, mq[0].taken, mq[0].dnpc);
    idle();
  endtask

  task automatic test_reset();
    model_reset();
    repeat (2) @(negedge clock);
    n_checks++;
    if (redirect_o !== 1'b0 || redirect_pc_o !== 32'h0 || error_o !== 1'b0 ||
        pred_ready_o !== 1'b1 || resolve_ready_o !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: got rdr=%b pc=%h err=%b prdy=%b rrdy=%b expected 0 0 0 1 0",
               redirect_o, redirect_pc_o, error_o, pred_ready_o, resolve_ready_o);
    end
    reset = 1'b1;
  endtask

  task automatic test_correct_not_taken();
    push_only(32'h8000_0010, 0, 32'h0);
    step(0, '0, 0, '0, 1, 32'h8000_0010, 0, 32'h0);
    idle();
    n_checks++;
    if (redirect_o !== 1'b0 || resolve_ready_o !== 1'b0) begin
      n_fail++;
      $display("FAIL not_taken: got rdr=%b rrdy=%b expected 0 0", redirect_o, resolve_ready_o);
    end
  endtask

  task automatic test_no_bypass();
    step(1, 32'h8000_0300, 0, 32'h0, 1, 32'h8000_0300, 0, 32'h0);
    n_checks++;
    if (mq.size() != 1) begin
      n_fail++;
      $display("FAIL no_bypass: model depth %0d expected 1", mq.size());
    end
    drain();
  endtask

  task automatic test_direction_mispredict();
    push_only(32'h8000_0020, 0, 32'h0);
    step(0, '0, 0, '0, 1, 32'h8000_0020, 1, 32'h8000_0100);
    step(1, 32'h8000_0104, 0, 32'h0, 0, '0, 0, '0);
    n_checks++;
    if (redirect_o !== 1'b1 || redirect_pc_o !== 32'h8000_0100 || pred_ready_o !== 1'b0) begin
      n_fail++;
      $display("FAIL dir_mispredict: got rdr=%b pc=%h prdy=%b expected 1 80000100 0",
               redirect_o, redirect_pc_o, pred_ready_o);
    end
    idle();
    n_checks++;
    if (redirect_o !== 1'b0 || pred_ready_o !== 1'b1) begin
      n_fail++;
      $display("FAIL dir_recover: got rdr=%b prdy=%b expected 0 1", redirect_o, pred_ready_o);
    end
  endtask

  task automatic test_target_flush();
    push_only(32'h8000_0000, 1, 32'h8000_0040);
    push_only(32'h8000_0040, 0, 32'h0);
    push_only(32'h8000_0044, 1, 32'h8000_0200);
    step(1, 32'h8000_0204, 0, 32'h0, 1, 32'h8000_0000, 1, 32'h8000_0080);
    idle();
    n_checks++;
    if (redirect_o !== 1'b1 || redirect_pc_o !== 32'h8000_0080) begin
      n_fail++;
      $display("FAIL target_redirect: got rdr=%b pc=%h expected 1 80000080", redirect_o, redirect_pc_o);
    end
    idle();
    n_checks++;
    if (resolve_ready_o !== 1'b0) begin
      n_fail++;
      $display("FAIL target_flush: resolve_ready_o got %b expected 0", resolve_ready_o);
    end
  endtask

  task automatic test_full();
    for (int i = 0; i < 4; i++) push_only(32'h8000_1000 + 32'(i * 4), 0, 32'h0);
    step(1, 32'h8000_1010, 0, 32'h0, 1, 32'h8000_1000, 0, 32'h0);
    n_checks++;
    if (pred_ready_o !== 1'b0 || resolve_ready_o !== 1'b1) begin
      n_fail++;
      $display("FAIL full_refuse: got prdy=%b rrdy=%b expected 0 1", pred_ready_o, resolve_ready_o);
    end
    push_only(32'h8000_1010, 0, 32'h0);
    n_checks++;
    if (pred_ready_o !== 1'b1 || mq.size() != 4) begin
      n_fail++;
      $display("FAIL full_retry: got prdy=%b depth=%0d expected 1 4", pred_ready_o, mq.size());
    end
    drain();
  endtask

  task automatic test_pc_mismatch();
    push_only(32'h8000_0004, 0, 32'h0);
    step(0, '0, 0, '0, 1, 32'h8000_0008, 0, 32'h0);
    idle();
    n_checks++;
    if (error_o !== 1'b1 || redirect_pc_o !== 32'h8000_000C) begin
      n_fail++;
      $display("FAIL pc_mismatch: got err=%b pc=%h expected 1 8000000c", error_o, redirect_pc_o);
    end
    repeat (3) idle();
    n_checks++;
    if (error_o !== 1'b1) begin
      n_fail++;
      $display("FAIL error_sticky: got %b expected 1", error_o);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] pc;
    logic        t;
    for (int i = 0; i < 16; i++) begin
      pc = 32'h8000_2000 + 32'(i * 16);
      t  = 1'($urandom_range(0, 1));
      if (mq.size() > 0)
        step(1, pc, t, 32'($urandom), 1, mq[0].pc, mq[0].taken, mq[0].dnpc);
      else
        push_only(pc, t, 32'($urandom));
    end
    // Two mispredicts as close as the FSM allows.
    step(0, '0, 0, '0, 1, mq[0].pc, ~mq[0].taken, mq[0].pc + 32'h40);
    idle();
    push_only(32'h8000_3000, 1, 32'h8000_3100);
    step(0, '0, 0, '0, 1, 32'h8000_3000, 1, 32'h8000_3200);
    idle();
    n_checks++;
    if (redirect_o !== 1'b1 || redirect_pc_o !== 32'h8000_3200) begin
      n_fail++;
      $display("FAIL second_mispredict: got rdr=%b pc=%h expected 1 80003200", redirect_o, redirect_pc_o);
    end
    idle();
  endtask

  task automatic test_reset_in_redirect();
    push_only(32'h8000_4000, 0, 32'h0);
    step(0, '0, 0, '0, 1, 32'h8000_4010, 0, 32'h0);
    idle();
    reset = 1'b0;
    #1;
    n_checks++;
    if (redirect_o !== 1'b0 || error_o !== 1'b0 || resolve_ready_o !== 1'b0 ||
        pred_ready_o !== 1'b1 || redirect_pc_o !== 32'h0) begin
      n_fail++;
      $display("FAIL async_reset: got rdr=%b err=%b rrdy=%b prdy=%b pc=%h expected 0 0 0 1 0",
               redirect_o, error_o, resolve_ready_o, pred_ready_o, redirect_pc_o);
    end
`ifdef BRANCH_RESOLVE_STAT_EN
    n_checks++;
    if (branch_cnt_o !== 32'h0 || mispredict_cnt_o !== 32'h0) begin
      n_fail++;
      $display("FAIL async_reset_cnt: got %0d/%0d expected 0/0", branch_cnt_o, mispredict_cnt_o);
    end
`endif
    model_reset();
    @(negedge clock);
    reset = 1'b1;
    idle();
    push_only(32'h8000_5000, 1, 32'h8000_5100);
    step(0, '0, 0, '0, 1, 32'h8000_5000, 1, 32'h8000_5100);
    idle();
  endtask

  initial begin
    model_reset();
    test_reset();
    test_correct_not_taken();
    test_no_bypass();
    test_direction_mispredict();
    test_target_flush();
    test_full();
    test_pc_mismatch();
    test_back_to_back();
    test_reset_in_redirect();
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL redirect_sb_leftover: got %0d pending expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
